// File: rtl/pulse_dispatch_pkg.sv
// Shared types, default widths and the lane-field helper for pulse_dispatch.
package pulse_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNT     = 2'd1,
    WAIT_SYNC = 2'd2,
    WAIT_ACK  = 2'd3
  } state_t;

  localparam int NUM_LANES_DEF = 4;
  localparam int DLY_W_DEF     = 8;
  localparam int TO_W_DEF      = 12;
  localparam int TIMEOUT_DEF   = 1024;

  // LSB of lane 'lane' inside a packed vector of w-bit fields.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/pulse_dispatch_lane_delay.sv
// One lane: loads a delay on 'load', counts down while 'run', fires one registered pulse.
// 'fire' is the combinational fire condition so the parent can leave COUNT on the same edge.
module lane_delay #(
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [DLY_W-1:0] dly,
  input  logic             en,
  output logic             pulse,
  output logic             fired,
  output logic             fire
);

  logic [DLY_W-1:0] cnt_q;
  logic             en_q;
  logic             fired_q;
  logic             pulse_q;

  assign fire = run && en_q && !fired_q && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      en_q    <= 1'b0;
      fired_q <= 1'b0;
      pulse_q <= 1'b0;
    end else if (load) begin
      cnt_q   <= dly;
      en_q    <= en;
      fired_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= fire;
      if (fire) begin
        fired_q <= 1'b1;
      end else if (run && en_q && !fired_q) begin
        cnt_q <= cnt_q - DLY_W'(1);
      end
    end
  end

  assign pulse = pulse_q;
  assign fired = fired_q;

endmodule

// File: rtl/pulse_dispatch.sv
// Fires one delayed pulse per enabled lane on start, then waits for the barrier's done/ack pair.
// Starts arriving while busy (or with an empty mask) are dropped; a watchdog aborts a stalled handshake.
module pulse_dispatch
  import pulse_dispatch_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int DLY_W     = DLY_W_DEF,
  parameter int TO_W      = TO_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_LANES-1:0]       lane_en,
  input  logic [NUM_LANES*DLY_W-1:0] lane_dly,
  output logic [NUM_LANES-1:0]       lane_pulse,
  input  logic                       sync_done,
  input  logic                       sync_ack,
  output logic                       busy,
  output logic                       done,
  output logic                       start_drop,
  output logic                       timeout,
  output logic                       err_spurious
);

  state_t               state_q;
  logic [NUM_LANES-1:0] en_q;
  logic [TO_W-1:0]      wd_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 drop_q;
  logic                 to_q;
  logic                 err_q;

  logic                 accept;
  logic                 run;
  logic                 wd_hit;
  logic [NUM_LANES-1:0] fire;
  logic [NUM_LANES-1:0] fired;
  logic [NUM_LANES-1:0] fired_nxt;

  assign accept    = (state_q == IDLE) && start && (lane_en != '0);
  assign run       = (state_q == COUNT);
  assign fired_nxt = fired | fire;
  assign wd_hit    = (TIMEOUT != 0) && (wd_q == TO_W'(TIMEOUT - 1));

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_delay #(.DLY_W(DLY_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .run   (run),
      .dly   (lane_dly[lane_lsb(i, DLY_W) +: DLY_W]),
      .en    (lane_en[i]),
      .pulse (lane_pulse[i]),
      .fired (fired[i]),
      .fire  (fire[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
      to_q   <= 1'b0;

      if (start && !accept) drop_q <= 1'b1;
      if (sync_done && state_q != WAIT_SYNC) err_q <= 1'b1;
      if (sync_ack && state_q != WAIT_SYNC && state_q != WAIT_ACK) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (accept) begin
            en_q    <= lane_en;
            busy_q  <= 1'b1;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          // Last lane fires on this edge: its pulse and the state change coincide.
          if (fired_nxt == en_q) begin
            wd_q    <= '0;
            state_q <= WAIT_SYNC;
          end
        end
        WAIT_SYNC: begin
          wd_q <= wd_q + TO_W'(1);
          if (sync_done) begin
            state_q <= WAIT_ACK;
          end else if (wd_hit) begin
            to_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        WAIT_ACK: begin
          wd_q <= wd_q + TO_W'(1);
          if (sync_ack) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (wd_hit) begin
            to_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign start_drop   = drop_q;
  assign timeout      = to_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_pulse_dispatch.sv
// Directed bench for pulse_dispatch (TIMEOUT=16); outputs sampled 1 time unit after each rising edge.
module tb_pulse_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  lane_en = '0;
  logic [31:0] lane_dly = '0;
  logic [3:0]  lane_pulse;
  logic        sync_done = 1'b0;
  logic        sync_ack = 1'b0;
  logic        busy, done, start_drop, timeout, err_spurious;

  int n_cmp = 0;
  int n_bad = 0;

  pulse_dispatch #(
    .NUM_LANES (4),
    .DLY_W     (8),
    .TO_W      (12),
    .TIMEOUT   (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .lane_en      (lane_en),
    .lane_dly     (lane_dly),
    .lane_pulse   (lane_pulse),
    .sync_done    (sync_done),
    .sync_ack     (sync_ack),
    .busy         (busy),
    .done         (done),
    .start_drop   (start_drop),
    .timeout      (timeout),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a start, then check every lane pulse lands (dly+1) edges after the sampling edge.
  // With restart=1 a second start arrives during COUNT and must be dropped.
  task automatic dispatch(input logic [3:0] en, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3, input bit restart);
    logic [7:0] d [4];
    logic [3:0] exp;
    int         maxd;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    maxd = 0;
    for (int i = 0; i < 4; i++) if (en[i] && int'(d[i]) > maxd) maxd = int'(d[i]);
    start = 1'b1; lane_en = en; lane_dly = {d3, d2, d1, d0};
    tick();
    start = 1'b0;
    chk("busy_on_accept", busy, 1);
    chk("no_drop_on_accept", start_drop, 0);
    for (int k = 1; k <= maxd + 2; k++) begin
      if (restart && k == 1) start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) exp[i] = en[i] && (int'(d[i]) + 1 == k);
      chk($sformatf("pulse_k%0d", k), lane_pulse, exp);
      chk($sformatf("drop_k%0d", k), start_drop, (restart && k == 1) ? 1 : 0);
    end
    chk("busy_in_wait", busy, 1);
  endtask

  task automatic handshake(input bit ack_with_done);
    sync_done = 1'b1; sync_ack = ack_with_done;
    tick();
    sync_done = 1'b0; sync_ack = 1'b0;
    chk("no_done_after_sync", done, 0);
    chk("busy_before_ack", busy, 1);
    sync_ack = 1'b1;
    tick();
    sync_ack = 1'b0;
    chk("done_after_ack", done, 1);
    chk("busy_after_ack", busy, 0);
    tick();
    chk("done_single", done, 0);
  endtask

  initial begin
    #2;
    chk("rst_pulse", lane_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", start_drop, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", err_spurious, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Staggered delays: one lane per cycle, then a clean handshake.
    dispatch(4'b1111, 8'd0, 8'd1, 8'd2, 8'd3, 1'b0);
    handshake(1'b0);
    chk("err_after_seq1", err_spurious, 0);

    // Equal delays on lanes 0 and 2; ack alongside done is ignored without error.
    dispatch(4'b0101, 8'd5, 8'd5, 8'd5, 8'd5, 1'b0);
    handshake(1'b1);
    chk("err_after_seq2", err_spurious, 0);

    // Empty mask is dropped in IDLE.
    start = 1'b1; lane_en = 4'b0000;
    tick();
    start = 1'b0;
    chk("drop_empty_mask", start_drop, 1);
    chk("busy_empty_mask", busy, 0);
    tick();
    chk("drop_empty_clear", start_drop, 0);

    // Start while in COUNT: one drop, timing unchanged, single done.
    dispatch(4'b0011, 8'd3, 8'd3, 8'd0, 8'd0, 1'b1);
    handshake(1'b0);

    // Watchdog: WAIT_SYNC entered on edge 1 after accept; abort 16 edges later.
    dispatch(4'b0001, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    for (int k = 3; k <= 16; k++) begin
      tick();
      chk($sformatf("no_timeout_e%0d", k), timeout, 0);
    end
    chk("busy_before_timeout", busy, 1);
    tick();
    chk("timeout_pulse", timeout, 1);
    chk("busy_after_timeout", busy, 0);
    chk("no_done_on_timeout", done, 0);
    tick();
    chk("timeout_single", timeout, 0);
    dispatch(4'b1000, 8'd0, 8'd0, 8'd0, 8'd2, 1'b0);
    handshake(1'b0);

    // Spurious ack in IDLE is sticky across a full sequence.
    sync_ack = 1'b1;
    tick();
    sync_ack = 1'b0;
    chk("err_set", err_spurious, 1);
    chk("err_no_state_change", busy, 0);
    dispatch(4'b0010, 8'd0, 8'd1, 8'd0, 8'd0, 1'b0);
    handshake(1'b0);
    chk("err_sticky", err_spurious, 1);

    // Reset mid-COUNT with lanes 0,1 fired and 2,3 pending.
    start = 1'b1; lane_en = 4'b1111; lane_dly = {8'd6, 8'd5, 8'd1, 8'd0};
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_l0", lane_pulse, 4'b0001);
    tick();
    chk("pre_rst_l1", lane_pulse, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pulse", lane_pulse, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err_spurious, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("post_rst_pulse%0d", k), lane_pulse, 0);
      chk($sformatf("post_rst_done%0d", k), done, 0);
    end
    chk("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
